// File: rtl/psram_ctrl.sv
// Quad PSRAM controller: one request at a time, sck = clock/2, nibble-wide data.
// Define PSRAM_CTRL_QPI_INIT_EN to send 0x35 after reset and use 2-cycle quad commands.
module psram_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dio_out,
   output logic [3:0]  dio_oe,
   input  logic [3:0]  dio_in
);

   typedef enum logic [2:0] {
      INIT, IDLE, CMD, ADDR, WAIT, DATA, CSHIGH
   } state_t;

`ifdef PSRAM_CTRL_QPI_INIT_EN
   localparam logic [7:0] QPI_CMD  = 8'h35;
   localparam logic [3:0] CMD_LAST = 4'd1;
`else
   localparam logic [3:0] CMD_LAST = 4'd7;
`endif

   state_t      st_q, st_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ph_q, ph_d;
   logic        sck_q, sck_d;
   logic        ce_n_q, ce_n_d;
   logic [3:0]  dout_q, dout_d;
   logic [3:0]  doe_q, doe_d;
   logic        rdy_q, rdy_d;
   logic        rsp_q, rsp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        we_q, we_d;
   logic [23:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;

   logic [3:0]  last_cnt;
   logic [1:0]  sz_eff;
   logic [7:0]  cmd;
   logic [2:0]  bi;
   logic [4:0]  apos;
   logic [4:0]  dpos_q;
   logic [4:0]  dpos_d;
   logic        load;
   logic        shift;

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      sck_d   = 1'b0;
      ce_n_d  = ce_n_q;
      dout_d  = dout_q;
      doe_d   = doe_q;
      rsp_d   = 1'b0;
      rdata_d = rdata_q;
      rbuf_d  = rbuf_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      load    = 1'b0;
      shift   = 1'b0;

      sz_eff = (size_q == 2'd3) ? 2'd2 : size_q;
      dpos_q = {cnt_q[2:1], ~cnt_q[0], 2'b00};
      last_cnt = 4'd7;
      if (st_q == CMD) last_cnt = CMD_LAST;
      if (st_q == ADDR) last_cnt = 4'd5;
      if (st_q == WAIT) last_cnt = 4'd6;
      if (st_q == DATA && we_q) last_cnt = (4'd2 << sz_eff) - 4'd1;

      unique case (st_q)
         INIT: begin
`ifdef PSRAM_CTRL_QPI_INIT_EN
            if (ce_n_q) begin
               ce_n_d = 1'b0;
               cnt_d  = 4'd0;
               ph_d   = 1'b0;
               load   = 1'b1;
            end else begin
               shift = 1'b1;
            end
`else
            st_d = IDLE;
`endif
         end
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               ce_n_d  = 1'b0;
               st_d    = CMD;
               cnt_d   = 4'd0;
               ph_d    = 1'b0;
               load    = 1'b1;
            end
         end
         CMD, ADDR, WAIT, DATA: shift = 1'b1;
         CSHIGH: begin
            if (cnt_q == 4'd1) begin
               st_d  = IDLE;
               cnt_d = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: st_d = INIT;
      endcase

      // First clock of each sck cycle raises sck; second lowers it and advances.
      if (shift) begin
         if (!ph_q) begin
            sck_d = 1'b1;
            ph_d  = 1'b1;
         end else begin
            ph_d = 1'b0;
            if (st_q == DATA && !we_q) rbuf_d[dpos_q +: 4] = dio_in;
            if (cnt_q != last_cnt) begin
               cnt_d = cnt_q + 4'd1;
               load  = 1'b1;
            end else begin
               cnt_d = 4'd0;
               unique case (st_q)
                  CMD: begin
                     st_d = ADDR;
                     load = 1'b1;
                  end
                  ADDR: begin
                     st_d = we_q ? DATA : WAIT;
                     load = 1'b1;
                  end
                  WAIT: begin
                     st_d = DATA;
                     load = 1'b1;
                  end
                  default: begin
                     st_d   = CSHIGH;
                     ce_n_d = 1'b1;
                     doe_d  = 4'h0;
                     dout_d = 4'h0;
                     rsp_d  = (st_q == DATA);
                     if (st_q == DATA && !we_q) rdata_d = rbuf_d;
                  end
               endcase
            end
         end
      end

      cmd    = we_d ? 8'h38 : 8'hEB;
      bi     = 3'd7 - cnt_d[2:0];
      apos   = 5'd20 - {cnt_d[2:0], 2'b00};
      dpos_d = {cnt_d[2:1], ~cnt_d[0], 2'b00};

      if (load) begin
         unique case (st_d)
`ifdef PSRAM_CTRL_QPI_INIT_EN
            INIT: begin
               doe_d  = 4'b0001;
               dout_d = {3'b000, QPI_CMD[bi]};
            end
            CMD: begin
               doe_d  = 4'b1111;
               dout_d = cnt_d[0] ? cmd[3:0] : cmd[7:4];
            end
`else
            CMD: begin
               doe_d  = 4'b0001;
               dout_d = {3'b000, cmd[bi]};
            end
`endif
            ADDR: begin
               doe_d  = 4'b1111;
               dout_d = addr_d[apos +: 4];
            end
            DATA: begin
               doe_d  = {4{we_d}};
               dout_d = we_d ? wdata_d[dpos_d +: 4] : 4'h0;
            end
            default: begin
               doe_d  = 4'h0;
               dout_d = 4'h0;
            end
         endcase
      end

      rdy_d = (st_d == IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q    <= INIT;
         cnt_q   <= 4'd0;
         ph_q    <= 1'b0;
         sck_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         dout_q  <= 4'h0;
         doe_q   <= 4'h0;
         rdy_q   <= 1'b0;
         rsp_q   <= 1'b0;
         rdata_q <= 32'h0;
         rbuf_q  <= 32'h0;
         we_q    <= 1'b0;
         addr_q  <= 24'h0;
         size_q  <= 2'd0;
         wdata_q <= 32'h0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         sck_q   <= sck_d;
         ce_n_q  <= ce_n_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
         rdy_q   <= rdy_d;
         rsp_q   <= rsp_d;
         rdata_q <= rdata_d;
         rbuf_q  <= rbuf_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
      end
   end

   assign req_ready  = rdy_q;
   assign resp_valid = rsp_q;
   assign resp_rdata = rdata_q;
   assign sck        = sck_q;
   assign ce_n       = ce_n_q;
   assign dio_out    = dout_q;
   assign dio_oe     = doe_q;

endmodule

// File: doc/psram_ctrl.md
PSRAM_CTRL -- requirements
Module: psram_ctrl

Interface
REQ-001 clock  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  request present.
REQ-004 req_ready  output  1  controller accepts request this cycle (IDLE only).
REQ-005 req_we  input  1  1 = write, 0 = read.
REQ-006 req_addr  input  24  byte address sent to device.
REQ-007 req_size  input  2  write size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal (treated as 2); ignored for reads.
REQ-008 req_wdata  input  32  write data, byte 0 in bits [7:0].
REQ-009 resp_valid  output  1  one-cycle pulse, transaction complete.
REQ-010 resp_rdata  output  32  read data, byte 0 in bits [7:0]; holds last value until next read completes.
REQ-011 sck  output  1  device serial clock.
REQ-012 ce_n  output  1  device chip select, active low.
REQ-013 dio_out  output  4  data to device.
REQ-014 dio_oe  output  4  per-bit output enable.
REQ-015 dio_in  input  4  data from device.

Function
REQ-016 sck SHALL be clock/2: in ACTIVE phases sck toggles every clock; outside them sck = 0.
REQ-017 dio_out/dio_oe SHALL change only on the clock edge driving sck 1->0 (or when ce_n falls); device samples on sck rising.
REQ-018 dio_in SHALL be sampled on the clock edge driving sck 1->0.
REQ-019 States: INIT, IDLE, CMD, ADDR, WAIT, DATA, CSHIGH.
REQ-020 IDLE: req_ready = 1; on req_valid capture all request fields; ce_n = 0; go CMD.
REQ-021 CMD: command byte MSB first; 0xEB read, 0x38 write; quad mode: 2 sck cycles, dio_oe = 1111.
REQ-022 ADDR: 6 sck cycles, dio_oe = 1111, addr[23:20] first.
REQ-023 WAIT (reads only): 7 sck cycles, dio_oe = 0000.
REQ-024 Read DATA: 8 sck cycles, dio_oe = 0000; nibble k (k = 0..7) = byte k/2, high nibble first (k even → [7:4]).
REQ-025 Write DATA: 2·(2^req_size) sck cycles, dio_oe = 1111; same nibble order as REQ-024 from req_wdata.
REQ-026 After last DATA cycle: ce_n = 1, sck = 0, dio_oe = 0; CSHIGH holds 2 clocks; resp_valid pulses on CSHIGH entry; resp_rdata updates in the same cycle for reads; then IDLE.
REQ-027 req_valid outside IDLE SHALL be ignored (no queuing); request fields are sampled only at acceptance.
REQ-028 Request accepted in the same cycle CSHIGH exits is not possible; minimum ce_n high time is 2 clocks.
REQ-029 Counters SHALL saturate-free wrap only via state exit; nibble counter width 4 bits.

Reset
REQ-030 While reset is high: ce_n = 1, sck = 0, dio_oe = 0, dio_out = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, state = INIT.
REQ-031 Reset mid-transaction SHALL abort immediately (ce_n high asynchronously); no response issued; request dropped.
REQ-032 First clock after reset deasserts: proceed per Configuration.

Configuration
REQ-033 Macro PSRAM_CTRL_QPI_INIT_EN.
REQ-034 Defined: INIT sends 0x35 in SPI mode (8 sck cycles, dio_out[0] only, dio_oe = 0001, MSB first), then CSHIGH (no resp_valid), then IDLE; all later commands use 2-cycle quad CMD.
REQ-035 Undefined: INIT goes straight to IDLE; every CMD phase is SPI (8 sck cycles on dio_out[0], dio_oe = 0001); ADDR/WAIT/DATA unchanged.

Verification
REQ-036 Reset release with macro defined -> one ce_n low window, 8 sck pulses, dio_out[0] bits 0,0,1,1,0,1,0,1; req_ready high 2 clocks after ce_n rises.
REQ-037 Write addr 0x000100, size 2, data 0x44332211 -> nibbles 3,8,0,0,0,1,0,0,1,1,2,2,3,3,4,4; device mem[0x100..0x103] = 11 22 33 44; one resp_valid.
REQ-038 Read addr 0x000100 after REQ-037 -> 7 WAIT cycles with dio_oe = 0; resp_rdata = 0x44332211.
REQ-039 Write addr 0x000201, size 0, data 0x000000AB -> exactly 2 DATA cycles (A, B); only byte 0x201 changes.
REQ-040 Assert reset during ADDR of a read -> ce_n rises immediately, no resp_valid; after reset, INIT replays and subsequent read returns correct data.
REQ-041 Macro undefined, read addr 0x000100 -> CMD uses 8 SPI cycles (0xEB on dio_out[0]), then ADDR/WAIT/DATA identical to REQ-038.
